mant_mul_seq: RTL

- Iterative radix-2 shift-add multiplier for FP16 significands (implicit bit included). It is the stage directly upstream of the exponent adder.
- Produces the raw 22-bit product and the normalisation bit `inc` that the exponent adder consumes.
- Produces the normalised 10-bit fraction plus guard/sticky bits for the downstream rounder.
- Sits in the FP16 multiplier datapath between operand unpack and exponent/round stages, with valid/ready handshake on both sides.

---
 rtl/fp16_pkg.sv | 16 +
 rtl/adder.sv | 12 +
 rtl/mant_normalize.sv | 29 ++
 rtl/mant_mul_seq.sv | 105 ++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared FP16 field widths and multiplier FSM encoding.
package fp16_pkg;

    localparam int EXP_BITS  = 5;
    localparam int FRAC_BITS = 10;
    localparam int MANT_BITS = FRAC_BITS + 1;
    localparam int BIAS      = 15;
    localparam int PROD_BITS = 2 * MANT_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/adder.sv
// Plain unsigned adder, carry-out dropped; combinational, no flow control.
module adder #(
    parameter int BITS = 22
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic [BITS-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/mant_normalize.sv
// Splits a significand product into inc/fraction/guard/sticky for rounding.
// Purely combinational, zero latency, no flow control.
module mant_normalize #(
    parameter int MANT_BITS = 11
) (
    input  logic [2*MANT_BITS-1:0] product,
    output logic                   inc,
    output logic [MANT_BITS-2:0]   mant,
    output logic                   guard,
    output logic                   sticky
);

    localparam int M = MANT_BITS;

    always_comb begin
        inc = product[2*M-1];
        if (inc) begin
            mant   = product[2*M-2:M];
            guard  = product[M-1];
            sticky = |product[M-2:0];
        end else begin
            // Product in [1,2): leading one sits one bit lower.
            mant   = product[2*M-3:M-1];
            guard  = product[M-2];
            sticky = |product[M-3:0];
        end
    end

endmodule

// File: rtl/mant_mul_seq.sv
// Radix-2 shift-add significand multiplier; MANT_BITS+1 cycles (1 on zero operand).
// Result held in DONE until out_ready; no new operands accepted until then.
module mant_mul_seq #(
    parameter int MANT_BITS = 11,
    parameter int TAG_BITS  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [MANT_BITS-1:0]   in_a,
    input  logic [MANT_BITS-1:0]   in_b,
    input  logic [TAG_BITS-1:0]    in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*MANT_BITS-1:0] out_product,
    output logic                   out_inc,
    output logic [MANT_BITS-2:0]   out_mant,
    output logic                   out_guard,
    output logic                   out_sticky,
    output logic [TAG_BITS-1:0]    out_tag
);
    import fp16_pkg::*;

    localparam int PW = 2 * MANT_BITS;
    localparam int CW = $clog2(MANT_BITS + 1);
    localparam logic [CW-1:0] LAST = CW'(MANT_BITS - 1);

    mul_state_t           state;
    logic [CW-1:0]        count;
    logic [MANT_BITS-1:0] a_q;
    logic [MANT_BITS-1:0] b_q;
    logic [PW-1:0]        addend;
    logic [PW-1:0]        sum;

    assign addend = b_q[count] ? ({{MANT_BITS{1'b0}}, a_q} << count) : '0;

    adder #(.BITS(PW)) u_acc_add (
        .a   (out_product),
        .b   (addend),
        .sum (sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_product <= '0;
            out_tag     <= '0;
            count       <= '0;
            a_q         <= '0;
            b_q         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q         <= in_a;
                        b_q         <= in_b;
                        out_tag     <= in_tag;
                        out_product <= '0;
                        count       <= '0;
                        in_ready    <= 1'b0;
                        if (in_a == '0 || in_b == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    out_product <= sum;
                    if (count == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    mant_normalize #(.MANT_BITS(MANT_BITS)) u_norm (
        .product (out_product),
        .inc     (out_inc),
        .mant    (out_mant),
        .guard   (out_guard),
        .sticky  (out_sticky)
    );

endmodule
